// File: rtl/bus_xbar_rr_if.sv
// bus_xbar_rr_if: shared-bus signal bundle between masters, crossbar and slaves
interface bus_xbar_rr_if #(
  parameter int NUM_M = 4,
  parameter int NUM_S = 8,
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic [NUM_M-1:0] m_req_;
  logic [NUM_M*ADDR_W-1:0] m_addr;
  logic [NUM_M-1:0] m_as_;
  logic [NUM_M-1:0] m_rw;
  logic [NUM_M*DATA_W-1:0] m_wr_data;
  logic [NUM_M-1:0] m_grnt_;
  logic [DATA_W-1:0] m_rd_data;
  logic m_rdy_;
  logic m_err;
  logic [ADDR_W-1:0] s_addr;
  logic s_as_;
  logic s_rw;
  logic [DATA_W-1:0] s_wr_data;
  logic [NUM_S-1:0] s_cs_;
  logic [NUM_S*DATA_W-1:0] s_rd_data;
  logic [NUM_S-1:0] s_rdy_;
  modport xbar (
    input m_req_, m_addr, m_as_, m_rw, m_wr_data, s_rd_data, s_rdy_,
    output m_grnt_, m_rd_data, m_rdy_, m_err, s_addr, s_as_, s_rw, s_wr_data, s_cs_
  );
  modport master (
    output m_req_, m_addr, m_as_, m_rw, m_wr_data,
    input m_grnt_, m_rd_data, m_rdy_, m_err
  );
  modport slave (
    input s_addr, s_as_, s_rw, s_wr_data, s_cs_,
    output s_rd_data, s_rdy_
  );
endinterface

// File: rtl/bus_xbar_rr.sv
// bus_xbar_rr: round-robin shared bus with ownership-gated chip selects and stall watchdog
module bus_xbar_rr #(
  parameter int NUM_M = 4,
  parameter int NUM_S = 8,
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int SEL_W = 3,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic reset,
  bus_xbar_rr_if.xbar b
);
  localparam int MW = $clog2(NUM_M);
  localparam int CW = TIMEOUT == 0 ? 1 : $clog2(TIMEOUT + 1);
  logic owner_vld_q, owner_vld_d;
  logic [MW-1:0] owner_q, owner_d, last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel;
  logic [NUM_S-1:0] cs_;
  logic [DATA_W-1:0] slv_data;
  logic mapped, slv_rdy_, stall, unmapped, to;
  // arbitration: keep the owner while it requests, else scan circularly from last+1
  always_comb begin
    owner_vld_d = owner_vld_q && !b.m_req_[owner_q];
    owner_d = owner_q;
    last_d = last_q;
    if (!owner_vld_d)
      for (int k = NUM_M; k >= 1; k--)
        for (int j = 0; j < NUM_M; j++)
          if (j == (int'(last_q) + k) % NUM_M && !b.m_req_[j]) begin
            owner_vld_d = 1'b1;
            owner_d = MW'(j);
            last_d = MW'(j);
          end
  end
  // grants are one-hot-low from the registered owner
  always_comb begin
    b.m_grnt_ = '1;
    for (int i = 0; i < NUM_M; i++)
      b.m_grnt_[i] = !(owner_vld_q && owner_q == MW'(i));
  end
  // master mux: owner drives the shared bus, an idle bus parks as a non-strobed read
  always_comb begin
    b.s_addr = '0;
    b.s_as_ = 1'b1;
    b.s_rw = 1'b1;
    b.s_wr_data = '0;
    for (int i = 0; i < NUM_M; i++)
      if (owner_vld_q && owner_q == MW'(i)) begin
        b.s_addr = b.m_addr[i*ADDR_W +: ADDR_W];
        b.s_as_ = b.m_as_[i];
        b.s_rw = b.m_rw[i];
        b.s_wr_data = b.m_wr_data[i*DATA_W +: DATA_W];
      end
  end
  assign sel = b.s_addr[ADDR_W-1 -: SEL_W];
  assign mapped = int'(sel) < NUM_S;
  // decode and slave mux: only an owned bus selects a slave
  always_comb begin
    cs_ = '1;
    slv_rdy_ = 1'b1;
    slv_data = '0;
    for (int i = 0; i < NUM_S; i++)
      if (owner_vld_q && int'(sel) == i) begin
        cs_[i] = 1'b0;
        slv_rdy_ = b.s_rdy_[i];
        slv_data = b.s_rd_data[i*DATA_W +: DATA_W];
      end
  end
  assign stall = owner_vld_q && !b.s_as_ && mapped && slv_rdy_;
  assign unmapped = owner_vld_q && !b.s_as_ && !mapped;
  assign to = TIMEOUT != 0 && stall && cnt_q == CW'(TIMEOUT);
  assign b.s_cs_ = cs_;
  assign b.m_err = unmapped || to;
  assign b.m_rdy_ = slv_rdy_ && !b.m_err;
  assign b.m_rd_data = b.m_err ? '0 : slv_data;
  // watchdog counts stalled cycles of one owner and restarts on any break in the stall
  always_comb begin
    cnt_d = (!stall || to || owner_vld_d != owner_vld_q || owner_d != owner_q) ? '0 : cnt_q + 1'b1;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_vld_q <= 1'b0;
      owner_q <= '0;
      last_q <= MW'(NUM_M - 1);
      cnt_q <= '0;
    end else begin
      owner_vld_q <= owner_vld_d;
      owner_q <= owner_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
